// File: rtl/uart_rxer_if.sv
// uart_rxer_if: serial line in, received-byte strobes out.
// slave  = receiver side (uart_rxer), master = line driver / byte consumer.
interface uart_rxer_if;
  logic       RX;
  logic [7:0] data_out;
  logic       en_data_out;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  modport master (output RX, input data_out, en_data_out, busy, frame_err, parity_err);
  modport slave  (input RX, output data_out, en_data_out, busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rxer.sv
// uart_rxer: 8N1 UART receiver, mid-bit sampling, one-cycle result strobes.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 (extra PARITY
// state, parity_err strobe); without it parity_err is tied low.
module uart_rxer #(
  parameter int BAUD_DIV = 5000,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clk,
  input  logic        res,
  uart_rxer_if.slave  rx_if
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BAUD_LAST = cnt_t'(BAUD_DIV - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] dout_q, dout_d;
  logic       en_q, en_d;
  logic       ferr_q, ferr_d;
  logic [1:0] sync_q;
  logic       prev_q;
  logic       rxs;
`ifdef UART_RX_PARITY_EN
  logic       perr_q, perr_d;
  logic       pbad_q, pbad_d;
`endif

  assign rxs = sync_q[1];

  // Two-flop synchroniser plus one-cycle delayed copy for edge detect.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_if.RX};
      prev_q <= rxs;
    end
  end

  // State, counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  // Next-state logic: sample at the last count of each bit window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid-start is a glitch, not a frame.
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          pbad_d  = (^sh_q) ^ rxs;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            // Leave at mid-stop so a zero-gap next start edge is caught.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) perr_d = 1'b1;
            else begin
              dout_d = sh_q;
              en_d   = 1'b1;
            end
`else
            dout_d = sh_q;
            en_d   = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_if.data_out    = dout_q;
  assign rx_if.en_data_out = en_q;
  assign rx_if.frame_err   = ferr_q;
  assign rx_if.busy        = (state_q != S_IDLE) && (state_q != S_BREAK);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err  = perr_q;
`else
  assign rx_if.parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rxer.sv
// tb_uart_rxer: table-driven frames with a scoreboard of expected strobes,
// plus hand sequences for false start and mid-frame reset.
module tb_uart_rxer;
  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  localparam logic [1:0] K_DATA = 2'd0, K_FERR = 2'd1, K_PERR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    int         hold_low;
    int         gap;
    logic [1:0] kind;
    logic [7:0] exp_do;
  } vec_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  uart_rxer_if u_if();
  uart_rxer #(.BAUD_DIV(BAUD)) dut (.clk(clk), .res(res), .rx_if(u_if));

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   t_fall = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[$];
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (res === 1'b1 && (u_if.en_data_out || u_if.frame_err || u_if.parity_err)) begin
      check("strobe_excl", 32'(u_if.en_data_out) + 32'(u_if.frame_err) + 32'(u_if.parity_err), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, u_if.en_data_out, u_if.frame_err, u_if.parity_err}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", u_if.en_data_out ? 32'(K_DATA) : u_if.frame_err ? 32'(K_FERR) : 32'(K_PERR),
              32'(mon_e.kind));
        check("data_out", 32'(u_if.data_out), 32'(mon_e.data));
        check("busy_at_strobe", 32'(u_if.busy), 0);
        if (mon_e.kind == K_DATA) begin
          n_chk++;
          if (cyc - t_fall >= 154 && cyc - t_fall <= 156) n_pass++;
          else $display("FAIL latency: got %0d expected 154..156", cyc - t_fall);
        end
      end
    end
  end

  // Drive one bit for a full period; entered and left at posedge+1.
  task automatic bit_out(input logic b);
    u_if.RX = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    t_fall = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        u_if.RX = d[i];
        repeat (HALF) @(posedge clk);
        #1;
        check("busy_mid", 32'(u_if.busy), 1);
        repeat (BAUD - HALF) @(posedge clk);
        #1;
      end else bit_out(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ pflip);
`endif
    bit_out(stop);
  endtask

  task automatic idle(input int n);
    u_if.RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt.push_back(vec_t'{8'h0A, 1'b1, 1'b0, 0, 20, K_DATA, 8'h0A});
    vt.push_back(vec_t'{8'h55, 1'b0, 1'b0, 40, 20, K_FERR, 8'h0A});
    vt.push_back(vec_t'{8'h33, 1'b1, 1'b0, 0, 20, K_DATA, 8'h33});
    vt.push_back(vec_t'{8'hFF, 1'b1, 1'b0, 0, 0, K_DATA, 8'hFF});
    vt.push_back(vec_t'{8'h00, 1'b1, 1'b0, 0, 20, K_DATA, 8'h00});
`ifdef UART_RX_PARITY_EN
    vt.push_back(vec_t'{8'h0A, 1'b1, 1'b0, 0, 20, K_DATA, 8'h0A});
    vt.push_back(vec_t'{8'h0A, 1'b1, 1'b1, 0, 20, K_PERR, 8'h0A});
`endif
    last_good = 8'h00;

    // Reset state
    res = 1'b0;
    u_if.RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(u_if.data_out), 0);
    check("rst_en", 32'(u_if.en_data_out), 0);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_ferr", 32'(u_if.frame_err), 0);
    check("rst_perr", 32'(u_if.parity_err), 0);
    res = 1'b1;
    idle(10);

    // Table frames
    for (int i = 0; i < vt.size(); i++) begin
      sb.push_back(exp_t'{vt[i].kind, vt[i].exp_do});
      send_frame(vt[i].data, vt[i].stop, vt[i].pflip);
      if (vt[i].hold_low > 0) begin
        u_if.RX = 1'b0;
        repeat (vt[i].hold_low) @(posedge clk);
        #1;
      end
      if (vt[i].gap > 0) idle(vt[i].gap);
      last_good = vt[i].exp_do;
    end

    // False start: 4-cycle low glitch
    u_if.RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("fs_busy_on", 32'(u_if.busy), 1);
    u_if.RX = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("fs_busy_off", 32'(u_if.busy), 0);
    idle(30);
    check("fs_data_out", 32'(u_if.data_out), 32'(last_good));

    // Reset during data bit 4 of 0xA5
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'(8'hA5 >> i));
    u_if.RX = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    check("mr_busy_pre", 32'(u_if.busy), 1);
    res = 1'b0;
    #1;
    check("mr_data_out", 32'(u_if.data_out), 0);
    check("mr_busy", 32'(u_if.busy), 0);
    check("mr_strobes", {29'd0, u_if.en_data_out, u_if.frame_err, u_if.parity_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    u_if.RX = 1'b1;
    res = 1'b1;
    idle(20);
    sb.push_back(exp_t'{K_DATA, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);

    for (int k = 0; k < 3000 && sb.size() > 0; k++) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
